// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer: collects digit/operator/digit/equals key events into the
// 14-bit Calculator operation word (op_string), holds it for a settle time,
// then captures the Calculator result with a one-cycle valid pulse.
// op_string layout: [13:10] operand A, [9:6] operand B, [5:4] zero,
// [3:0] one-hot opcode (add=0001, sub=0010, and=0100, or=1000).
module calc_key_sequencer #(
   parameter int SETTLE_CYCLES = 2,
   parameter int KEY_W         = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_valid,
   input  logic [KEY_W-1:0] key_code,
   output logic [13:0]      op_string,
   input  logic [3:0]       res,
   output logic             busy,
   output logic [3:0]       result,
   output logic             result_valid,
   output logic             err
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GOT_A  = 3'd1,
      S_GOT_OP = 3'd2,
      S_GOT_B  = 3'd3,
      S_ISSUE  = 3'd4,
      S_SETTLE = 3'd5
   } state_t;

   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

   // Operator keys 16..19 map to opcode bits 0..3 via their two low bits.
   function automatic logic [3:0] op_onehot(input logic [1:0] sel);
      logic [3:0] code;
      case (sel)
         2'd0:    code = 4'b0001;
         2'd1:    code = 4'b0010;
         2'd2:    code = 4'b0100;
         2'd3:    code = 4'b1000;
         default: code = 4'b0000;
      endcase
      return code;
   endfunction

   state_t      state_r, state_s;
   logic [3:0]  a_r, a_s, b_r, b_s, op_r, op_s, result_r, result_s, cnt_r, cnt_s;
   logic [13:0] str_r, str_s;
   logic        rv_r, rv_s, err_r, err_s, busy_r, busy_s;
   logic        is_dig_s, is_op_s, is_eq_s, is_clr_s, is_ill_s;

   assign is_dig_s = (key_code < KEY_W'(16));
   assign is_op_s  = (key_code >= KEY_W'(16)) && (key_code <= KEY_W'(19));
   assign is_eq_s  = (key_code == KEY_W'(20));
   assign is_clr_s = (key_code == KEY_W'(21));
   assign is_ill_s = (key_code >= KEY_W'(22));

   // Next-state and next-datapath decode; keys are only acted on in non-busy states.
   always_comb begin
      state_s  = state_r;
      a_s      = a_r;
      b_s      = b_r;
      op_s     = op_r;
      str_s    = str_r;
      cnt_s    = cnt_r;
      result_s = result_r;
      rv_s     = 1'b0;
      err_s    = err_r;
      case (state_r)
         S_ISSUE: begin
            str_s   = {a_r, b_r, 2'b00, op_r};
            cnt_s   = SETTLE_INIT;
            state_s = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_r == 4'd0) begin
               result_s = res;
               rv_s     = 1'b1;
               state_s  = S_IDLE;
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         S_IDLE, S_GOT_A, S_GOT_OP, S_GOT_B: begin
            if (!key_valid) begin
               state_s = state_r;
            end else if (is_clr_s) begin
               state_s = S_IDLE;
               a_s     = 4'd0;
               b_s     = 4'd0;
               op_s    = 4'd0;
               str_s   = 14'd0;
               err_s   = 1'b0;
            end else if (is_ill_s) begin
               err_s   = 1'b1;
               state_s = S_IDLE;
            end else begin
               case (state_r)
                  S_IDLE: begin
                     if (is_dig_s) begin
                        a_s     = key_code[3:0];
                        state_s = S_GOT_A;
                     end else begin
                        err_s   = 1'b1;
                        state_s = S_IDLE;
                     end
                  end
                  S_GOT_A: begin
                     if (is_dig_s) begin
                        a_s = key_code[3:0];
                     end else if (is_op_s) begin
                        op_s    = op_onehot(key_code[1:0]);
                        state_s = S_GOT_OP;
                     end else begin
                        err_s   = 1'b1;
                        state_s = S_IDLE;
                     end
                  end
                  S_GOT_OP: begin
                     if (is_op_s) begin
                        op_s = op_onehot(key_code[1:0]);
                     end else if (is_dig_s) begin
                        b_s     = key_code[3:0];
                        state_s = S_GOT_B;
                     end else begin
                        err_s   = 1'b1;
                        state_s = S_IDLE;
                     end
                  end
                  S_GOT_B: begin
                     if (is_dig_s) begin
                        b_s = key_code[3:0];
                     end else if (is_eq_s) begin
                        state_s = S_ISSUE;
                     end else begin
                        // A second operator after B has no defined meaning; hold.
                        state_s = state_r;
                     end
                  end
                  default: state_s = S_IDLE;
               endcase
            end
         end
         default: state_s = S_IDLE;
      endcase
      busy_s = (state_s == S_ISSUE) || (state_s == S_SETTLE);
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r  <= S_IDLE;
         a_r      <= 4'd0;
         b_r      <= 4'd0;
         op_r     <= 4'd0;
         str_r    <= 14'd0;
         cnt_r    <= 4'd0;
         result_r <= 4'd0;
         rv_r     <= 1'b0;
         err_r    <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         a_r      <= a_s;
         b_r      <= b_s;
         op_r     <= op_s;
         str_r    <= str_s;
         cnt_r    <= cnt_s;
         result_r <= result_s;
         rv_r     <= rv_s;
         err_r    <= err_s;
         busy_r   <= busy_s;
      end
   end

   assign op_string    = str_r;
   assign busy         = busy_r;
   assign result       = result_r;
   assign result_valid = rv_r;
   assign err          = err_r;

endmodule
